// File: rtl/life_pkg.sv
// Shared constants and scan-state encoding for the life-board display scanner.
package life_pkg;

    localparam int BOARD_W = 64;
    localparam int ROWS    = 8;
    localparam int COLS    = 8;
    localparam int ROW_W   = $clog2(ROWS);
    localparam int DWELL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_BLANK = 2'd2
    } scan_state_e;

endpackage

// File: rtl/scan_timer.sv
// Per-row dwell timer: load to DWELL-1, count down to zero, flag expiry at zero.
module scan_timer
    import life_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic expired
);

    localparam logic [DWELL_W-1:0] LOAD_VAL = DWELL_W'(DWELL - 1);

    logic [DWELL_W-1:0] count_q;
    logic [DWELL_W-1:0] count_d;

    always_comb begin
        // NOTE: default assignment first so every path drives count_d; otherwise a latch is inferred.
        count_d = count_q;
        if (load) begin
            count_d = LOAD_VAL;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - DWELL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == '0);

endmodule

// File: rtl/life_display_scan.sv
// Row-multiplexed 8x8 display scanner: captures a board snapshot, drives each row
// for DWELL cycles with a one-cycle blank between rows, and pulses frame_done at the end.
module life_display_scan
    import life_pkg::*;
#(
    parameter int DWELL = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BOARD_W-1:0] board,
    input  logic               board_valid,
    output logic               board_ready,
    output logic [ROWS-1:0]    row_sel,
    output logic [COLS-1:0]    col_data,
    output logic               frame_done,
    output logic               busy
);

    scan_state_e        state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [BOARD_W-1:0] snap_q, snap_d;
    logic               done_q, done_d;
    logic               ready_en_q, ready_en_d;

    logic tmr_load;
    logic tmr_dec;
    logic tmr_expired;
    logic take;

    scan_timer #(
        .DWELL (DWELL)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (tmr_load),
        .dec     (tmr_dec),
        .expired (tmr_expired)
    );

    // Ready is held off until the first edge after reset release.
    assign board_ready = ready_en_q && (state_q == ST_IDLE);
    assign take        = board_valid && board_ready;
    assign ready_en_d  = 1'b1;

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        snap_d   = snap_q;
        done_d   = 1'b0;
        tmr_load = 1'b0;
        tmr_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    snap_d   = board;
                    row_d    = '0;
                    state_d  = ST_SCAN;
                    tmr_load = 1'b1;
                end
            end
            ST_SCAN: begin
                if (tmr_expired) begin
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_BLANK;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_BLANK: begin
                state_d  = ST_SCAN;
                row_d    = row_q + ROW_W'(1);
                tmr_load = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            row_q      <= '0;
            // NOTE: the snapshot is a plain register bank, not a RAM, so it takes the reset like any other flop.
            snap_q     <= '0;
            done_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            snap_q     <= snap_d;
            done_q     <= done_d;
            ready_en_q <= ready_en_d;
        end
    end

    // Outputs decode from registered state and snapshot only; board inputs never reach them.
    always_comb begin
        row_sel  = '0;
        col_data = '0;
        if (state_q == ST_SCAN) begin
            row_sel  = ROWS'(1) << row_q;
            col_data = snap_q[row_q * COLS +: COLS];
        end
    end

    assign frame_done = done_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
